// File: rtl/apb_biu.sv
// APB slave to simple BIU master bridge; one transfer outstanding, one wait state minimum.
// Optional accept timeout: define APB_BIU_ACCEPT_TIMEOUT_EN.
module apb_biu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] apb_paddr,
  input  logic                  apb_psel,
  input  logic                  apb_penable,
  input  logic                  apb_pwrite,
  input  logic [DATA_WIDTH-1:0] apb_pwdata,
  output logic [DATA_WIDTH-1:0] apb_prdata,
  output logic                  apb_pready,
  output logic [ADDR_WIDTH-1:0] biu_addr,
  output logic                  biu_enable,
  output logic                  biu_rnw,
  output logic [DATA_WIDTH-1:0] biu_wdata,
  input  logic [DATA_WIDTH-1:0] biu_rdata,
  input  logic                  biu_accept
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   timeout_hit;

`ifdef APB_BIU_ACCEPT_TIMEOUT_EN
  logic [3:0] req_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)             req_cnt <= '0;
    else if (state != REQ) req_cnt <= '0;
    else                   req_cnt <= req_cnt + 4'd1;
  end

  // Sixteenth REQ cycle without accept gives up on the BIU.
  assign timeout_hit = (state == REQ) && !biu_accept && (req_cnt == 4'hF);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (apb_psel) state_nxt = REQ;
      // A master that walked away during REQ gets no pready.
      REQ:  if (biu_accept || timeout_hit) state_nxt = apb_psel ? DONE : IDLE;
      DONE: if (!apb_psel || apb_penable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      biu_addr   <= '0;
      biu_wdata  <= '0;
      biu_rnw    <= 1'b1;
      apb_prdata <= '0;
    end else begin
      if (state == IDLE && apb_psel) begin
        biu_addr  <= apb_paddr;
        biu_wdata <= apb_pwdata;
        biu_rnw   <= !apb_pwrite;
      end
      if (state == REQ && biu_accept)
        apb_prdata <= biu_rnw ? biu_rdata : '0;
      else if (timeout_hit)
        apb_prdata <= '1;
    end
  end

  assign biu_enable = (state == REQ);
  assign apb_pready = (state == DONE);

endmodule

// File: tb/tb_apb_biu.sv
// Directed bench for apb_biu with a scoreboard of expected transfer results.
module tb_apb_biu;

  logic        clk;
  logic        nrst;
  logic [31:0] apb_paddr;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic [31:0] biu_addr;
  logic        biu_enable;
  logic        biu_rnw;
  logic [31:0] biu_wdata;
  logic [31:0] biu_rdata;
  logic        biu_accept;

  apb_biu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready),
    .biu_addr(biu_addr), .biu_enable(biu_enable), .biu_rnw(biu_rnw),
    .biu_wdata(biu_wdata), .biu_rdata(biu_rdata), .biu_accept(biu_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] wdata;
    logic [31:0] prdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check1({tag, "_enable"}, biu_enable, 1'b0);
    check1({tag, "_pready"}, apb_pready, 1'b0);
    check ({tag, "_prdata"}, apb_prdata, 32'h0);
    check ({tag, "_addr"},   biu_addr,   32'h0);
    check ({tag, "_wdata"},  biu_wdata,  32'h0);
    check1({tag, "_rnw"},    biu_rnw,    1'b1);
  endtask

  // Full APB transfer; the BIU accepts on enable cycle number 'delay' (0-based).
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int delay, input int exp_en, input logic [31:0] exp_prdata);
    exp_t e;
    exp_t cur;
    logic got;
    logic stable;
    int   en_cnt;
    e.addr = addr; e.rnw = !wr; e.wdata = wdata; e.prdata = exp_prdata;
    sb.push_back(e);
    cur = e;
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr;
    apb_paddr = addr; apb_pwdata = wdata; biu_rdata = rdata; biu_accept = 1'b0;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    got = 1'b0; stable = 1'b1; en_cnt = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (apb_pready) begin
        got = 1'b1;
        e = sb.pop_front();
        check({tag, "_prdata"}, apb_prdata, e.prdata);
        check1({tag, "_enable_off_in_done"}, biu_enable, 1'b0);
        biu_accept = 1'b0;
      end else if (biu_enable) begin
        if (en_cnt == 0) begin
          check ({tag, "_addr"},  biu_addr,  cur.addr);
          check1({tag, "_rnw"},   biu_rnw,   cur.rnw);
          check ({tag, "_wdata"}, biu_wdata, cur.wdata);
        end
        if (biu_addr !== cur.addr || biu_rnw !== cur.rnw || biu_wdata !== cur.wdata)
          stable = 1'b0;
        en_cnt++;
        biu_accept = (en_cnt == delay + 1);
      end
    end
    check1({tag, "_completed"}, got, 1'b1);
    if (!got && sb.size() > 0) void'(sb.pop_front());
    check1({tag, "_req_stable"}, stable, 1'b1);
    check({tag, "_enable_cycles"}, en_cnt, exp_en);
    @(posedge clk); #1;
    apb_psel = 1'b0; apb_penable = 1'b0; biu_accept = 1'b0;
    @(negedge clk);
    check1({tag, "_pready_one_cycle"}, apb_pready, 1'b0);
    check1({tag, "_idle_enable"}, biu_enable, 1'b0);
  endtask

  initial begin
    logic quiet;
    nrst = 1'b0;
    apb_paddr = '0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    apb_pwdata = '0; biu_rdata = '0; biu_accept = 1'b0;
    #12;
    check_reset("por");
    @(negedge clk); nrst = 1'b1;

    // Basic read, then write after one idle cycle.
    xfer("rd_c", 1'b0, 32'h0000_000C, 32'h0, 32'hFEFE_FAFA, 0, 1, 32'hFEFE_FAFA);
    xfer("wr_c", 1'b1, 32'h0000_000C, 32'hF1F2_F3F4, 32'h5555_AAAA, 0, 1, 32'h0);

    // prdata holds while rdata wiggles outside an accept.
    biu_rdata = 32'h1111_1111;
    repeat (3) @(negedge clk);
    check("prdata_hold", apb_prdata, 32'h0);

    xfer("b2b_rd", 1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_5A5A, 0, 1, 32'hA5A5_5A5A);
    xfer("b2b_wr", 1'b1, 32'h0000_0104, 32'h0BAD_CAFE, 32'h0, 0, 1, 32'h0);
    xfer("dly_rd", 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 3, 4, 32'h1234_5678);

    // Master drops psel mid-REQ: BIU still finishes, prdata updates, no pready.
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0;
    apb_paddr = 32'h0000_0080; biu_rdata = 32'hCAFE_F00D; biu_accept = 1'b0;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    @(negedge clk);
    check1("drop_enable", biu_enable, 1'b1);
    apb_psel = 1'b0; apb_penable = 1'b0;
    @(negedge clk);
    check1("drop_still_req", biu_enable, 1'b1);
    biu_accept = 1'b1;
    @(negedge clk);
    biu_accept = 1'b0;
    check1("drop_no_pready", apb_pready, 1'b0);
    check1("drop_enable_off", biu_enable, 1'b0);
    check("drop_prdata", apb_prdata, 32'hCAFE_F00D);
    @(negedge clk);
    check1("drop_idle_pready", apb_pready, 1'b0);

    // Asynchronous reset while in REQ.
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1;
    apb_paddr = 32'h0000_0200; apb_pwdata = 32'hDEAD_BEEF; biu_accept = 1'b0;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    repeat (2) @(negedge clk);
    check1("rst_pre_enable", biu_enable, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check_reset("midrst");
    apb_psel = 1'b0; apb_penable = 1'b0;
    @(negedge clk); nrst = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (apb_pready || biu_enable) quiet = 1'b0;
    end
    check1("post_rst_quiet", quiet, 1'b1);

`ifdef APB_BIU_ACCEPT_TIMEOUT_EN
    xfer("tmo_rd", 1'b0, 32'h0000_0300, 32'h0, 32'h0, 1000, 16, 32'hFFFF_FFFF);
`endif

    xfer("final_rd", 1'b0, 32'h0000_0010, 32'h0, 32'h0F0F_0F0F, 1, 2, 32'h0F0F_0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_biu.md
APB_BIU -- requirements
Module: apb_biu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of the APB and BIU sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of the APB and BIU sides.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; nrst  in  1  async active-low reset.
REQ-004 SHALL have the APB slave ports:
- apb_paddr  in  ADDR_WIDTH  address
- apb_psel  in  1  select
- apb_penable  in  1  access phase
- apb_pwrite  in  1  1=write
- apb_pwdata  in  DATA_WIDTH  write data
- apb_prdata  out  DATA_WIDTH  read data
- apb_pready  out  1  transfer complete
REQ-005 SHALL have the BIU master ports:
- biu_addr  out  ADDR_WIDTH  request address
- biu_enable  out  1  request valid
- biu_rnw  out  1  1=read, 0=write
- biu_wdata  out  DATA_WIDTH  write data
- biu_rdata  in  DATA_WIDTH  read data, valid with biu_accept
- biu_accept  in  1  request accepted/completed this cycle

Function
REQ-006 SHALL implement a registered FSM with states IDLE, REQ and DONE.
REQ-007 In IDLE, apb_psel=1 SHALL latch apb_paddr, !apb_pwrite and apb_pwdata into biu_addr, biu_rnw and biu_wdata, and move to REQ (either APB phase starts a transfer).
REQ-008 In REQ, biu_enable SHALL be 1; biu_addr, biu_rnw and biu_wdata SHALL be held stable.
REQ-009 When biu_accept=1 is sampled in REQ, the FSM SHALL move to DONE and biu_enable SHALL be 0 from the next cycle.
REQ-010 On that accept edge, apb_prdata SHALL load biu_rdata for a read and 0 for a write.
REQ-011 apb_prdata SHALL otherwise hold its value.
REQ-012 In DONE, apb_pready SHALL be 1; apb_pready SHALL be 0 in all other states.
REQ-013 DONE SHALL return to IDLE when apb_psel & apb_penable is sampled, or immediately if apb_psel=0.
REQ-014 Latency with biu_accept tied high: setup edge -> REQ (1 cycle of biu_enable) -> DONE (1 cycle of apb_pready) -> IDLE, which is one APB wait state.
REQ-015 If apb_psel drops during REQ, the BIU request SHALL still complete and the FSM SHALL then go to IDLE, with the result discarded and prdata still updated.
REQ-016 Only one transfer SHALL be outstanding; no new latch occurs outside IDLE.
REQ-017 biu_enable SHALL never be 1 for two transfers without passing through IDLE.

Reset
REQ-018 nrst=0 SHALL asynchronously force IDLE and set biu_enable=0, apb_pready=0, apb_prdata=0, biu_addr=0, biu_wdata=0 and biu_rnw=1.
REQ-019 Reset mid-transfer SHALL abort the transfer with no pready.

Configuration
REQ-020 With APB_BIU_ACCEPT_TIMEOUT_EN defined, a 4-bit counter SHALL count REQ cycles; if biu_accept is not seen within 16 cycles, the FSM SHALL drop biu_enable, load apb_prdata with all ones and go to DONE.
REQ-021 Without APB_BIU_ACCEPT_TIMEOUT_EN, REQ SHALL wait indefinitely for biu_accept, and no counter logic is present.

Verification
REQ-022 Read: biu_accept=1, biu_rdata=0xFEFEFAFA, APB read of 0x0000000C -> one cycle of biu_enable with biu_addr=0xC and biu_rnw=1; apb_pready=1 for one cycle; apb_prdata=0xFEFEFAFA.
REQ-023 Write: APB write of 0x0000000C, data 0xF1F2F3F4 -> biu_enable for one cycle with biu_rnw=0 and biu_wdata=0xF1F2F3F4; apb_pready=1 for one cycle; apb_prdata=0.
REQ-024 Delayed accept: biu_accept asserted 3 cycles after biu_enable -> biu_enable high 4 cycles with stable address; apb_pready stays 0 until the cycle after accept.
REQ-025 Reset: nrst pulsed low while in REQ -> all outputs return to reset values immediately; no apb_pready.
REQ-026 Back-to-back: read then write with one idle cycle between -> two independent biu_enable pulses, each with correct addr, rnw and data.
REQ-027 With APB_BIU_ACCEPT_TIMEOUT_EN and biu_accept=0 -> after 16 REQ cycles, apb_pready=1 and apb_prdata=0xFFFFFFFF.
